timer_display: RTL

//  Reader side of the countdown timer: consumes the 8-bit seconds value and the scoreZero flag.

---
 rtl/timer_display_pkg.sv | 32 +++
 rtl/timer_display_bin2bcd_seq.sv | 43 ++++
 rtl/timer_display.sv | 76 +++++++
 3 files changed

// File: rtl/timer_display_pkg.sv
// timer_display_pkg: FSM states, 7-segment codes and the BCD-to-segment decoder
// shared by the countdown display and its double-dabble converter.
package timer_display_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
    // Segment codes are {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0: return SEG_0;
            4'd1: return SEG_1;
            4'd2: return SEG_2;
            4'd3: return SEG_3;
            4'd4: return SEG_4;
            4'd5: return SEG_5;
            4'd6: return SEG_6;
            4'd7: return SEG_7;
            4'd8: return SEG_8;
            4'd9: return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/timer_display_bin2bcd_seq.sv
// timer_display_bin2bcd_seq: sequential double-dabble, 8-bit binary to 3 BCD digits
// in 8 shift cycles; bcd is valid while done is high.
module timer_display_bin2bcd_seq
    import timer_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);
    state_t      r_state, w_next;
    logic [19:0] r_sr, w_adj;
    logic [2:0]  r_cnt;
    always_comb begin
        w_next = r_state == ST_IDLE  ? (start ? ST_SHIFT : ST_IDLE) :
                 r_state == ST_SHIFT ? (r_cnt == 3'd7 ? ST_DONE : ST_SHIFT) : ST_IDLE;
        w_adj = r_sr;
        for (int k = 0; k < 3; k++)
            w_adj[8+4*k +: 4] = r_sr[8+4*k +: 4] >= 4'd5 ? r_sr[8+4*k +: 4] + 4'd3 : r_sr[8+4*k +: 4];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && start) begin
                r_sr  <= {12'd0, bin};
                r_cnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_sr  <= w_adj << 1;
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end
    assign busy = r_state != ST_IDLE;
    assign done = r_state == ST_DONE;
    assign bcd  = r_sr[19:8];
endmodule

// File: rtl/timer_display.sv
// timer_display: converts the timer's seconds to BCD and scans 4 active-low 7-seg digits.
// Optional blinking while scoreZero is high is enabled by defining TIMER_DISP_BLINK_EN.
module timer_display
    import timer_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seconds,
    input  logic       scoreZero,
    input  logic       blink_tick,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy
);
    localparam int CW = $clog2(REFRESH_DIV);
    logic [7:0]    r_last;
    logic [3:0]    r_h, r_t, r_o, w_digit, w_an;
    logic [1:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [11:0]   w_bcd;
    logic [6:0]    w_seg;
    logic          w_start, w_cvt_busy, w_done, w_term, w_blank, w_blink;
    // A new conversion is only launched from idle, so mid-flight changes wait their turn.
    assign w_start = !w_cvt_busy && seconds != r_last;
    assign w_term  = r_cnt == CW'(REFRESH_DIV - 1);
    assign dp      = 1'b1;
    timer_display_bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .bin   (seconds),
        .busy  (w_cvt_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );
`ifdef TIMER_DISP_BLINK_EN
    logic r_blink;
    always_ff @(posedge clk) begin
        if (rst || !scoreZero) r_blink <= 1'b0;
        else if (blink_tick)   r_blink <= ~r_blink;
    end
    assign w_blink = r_blink & scoreZero;
`else
    logic w_unused;
    assign w_unused = &{1'b0, blink_tick, scoreZero};
    assign w_blink  = 1'b0;
`endif
    always_comb begin
        w_digit = r_idx == 2'd0 ? r_o : r_idx == 2'd1 ? r_t : r_h;
        w_blank = r_idx == 2'd3 || (r_idx == 2'd2 && r_h == 4'd0);
        w_seg   = w_blank ? SEG_BLANK : bcd_to_seg(w_digit);
        w_an    = w_blink ? 4'b1111 : ~(4'b0001 << r_idx);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= '0;
            {r_h, r_t, r_o} <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            seg    <= SEG_0;
            an     <= 4'b1110;
            busy   <= 1'b0;
        end else begin
            if (w_start) r_last <= seconds;
            if (w_done) {r_h, r_t, r_o} <= w_bcd;
            r_cnt  <= w_term ? '0 : r_cnt + CW'(1);
            r_idx  <= w_term ? r_idx + 2'd1 : r_idx;
            seg    <= w_seg;
            an     <= w_an;
            busy   <= w_cvt_busy;
        end
    end
endmodule
